amp_fault_monitor: RTL and testbench

AMP_FAULT_MONITOR -- requirements
Module: amp_fault_monitor

---
 rtl/amp_fault_monitor_pkg.sv | 27 ++
 rtl/amp_fault_monitor_float_mag_cmp.sv | 27 ++
 rtl/amp_fault_monitor.sv | 135 +++++++++++++
 tb/tb_amp_fault_monitor.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/amp_fault_monitor_pkg.sv
// Shared definitions for the amplifier fault monitor: state encoding,
// fault-code bit positions and float32 field constants.
package amp_fault_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_NORMAL = 2'd1,
        ST_WARN   = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    localparam int FC_PHASE_A = 0;
    localparam int FC_PHASE_B = 1;
    localparam int FC_PHASE_C = 2;
    localparam int FC_UNBAL   = 3;

    localparam logic [7:0] EXP_ALL_ONES = 8'hFF;
    localparam int         EXP_MSB      = 30;
    localparam int         EXP_LSB      = 23;

    // State reached after a bad frame once the debounce count has been advanced.
    function automatic state_t escalate(input logic [3:0] bad_count,
                                        input logic [3:0] debounce);
        return (bad_count >= debounce) ? ST_FAULT : ST_WARN;
    endfunction

endpackage

// File: rtl/amp_fault_monitor_float_mag_cmp.sv
// Combinational |x| > |TH| comparator on float32 bit patterns; an Inf/NaN
// input always reports "greater" so corrupted data can never mask a fault.
module FloatMagCmp
    import amp_fault_monitor_pkg::*;
#(
    parameter logic [31:0] TH = 32'h0000_0000
) (
    input  logic [31:0] x,
    output logic        gt
);

    localparam logic [31:0] TH_MAG = {1'b0, TH[30:0]};

    logic [31:0] mag;
    logic        inf_nan;

    // Non-negative IEEE-754 values order the same way as their bit patterns,
    // so clearing the sign bit turns the magnitude test into an unsigned compare.
    always_comb begin
        mag     = x;
        mag[31] = 1'b0;
    end

    assign inf_nan = (mag[EXP_MSB:EXP_LSB] == EXP_ALL_ONES);
    assign gt      = inf_nan || (mag > TH_MAG);

endmodule

// File: rtl/amp_fault_monitor.sv
// Per-frame amplitude/unbalance evaluation with a debounced
// IDLE/NORMAL/WARN/FAULT state machine and a latched fault code.
module amp_fault_monitor
    import amp_fault_monitor_pkg::*;
#(
    parameter logic [31:0] OVER_TH    = 32'h42C80000,
    parameter logic [31:0] UNBAL_TH   = 32'h3DCCCCCD,
    parameter int unsigned DEBOUNCE_N = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             dataOut,
    input  logic [2:0][31:0] Amp,
    input  logic [31:0]      Coff,
    input  logic             clearFault,
    output logic [1:0]       state,
    output logic             faultFlag,
    output logic             warnFlag,
    output logic [3:0]       faultCode,
    output logic [15:0]      frameCnt,
    output logic             evalDone
);

    localparam logic [3:0] DEB = 4'(DEBOUNCE_N);

    state_t      cur_state;
    state_t      nxt_state;
    logic [3:0]  bad_cnt;
    logic [3:0]  nxt_cnt;
    logic [3:0]  cnt_inc;
    logic [3:0]  nxt_code;
    logic [3:0]  bad_bits;
    logic        frame_bad;
    logic        frame_det;
    logic        data_prev;

    // ------------------------------------------------------------------
    // Threshold comparators: one per phase amplitude plus the unbalance.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < 3; i++) begin : g_phase
        FloatMagCmp #(.TH(OVER_TH)) u_amp_cmp (
            .x  (Amp[i]),
            .gt (bad_bits[FC_PHASE_A + i])
        );
    end

    FloatMagCmp #(.TH(UNBAL_TH)) u_unbal_cmp (
        .x  (Coff),
        .gt (bad_bits[FC_UNBAL])
    );

    assign frame_bad = |bad_bits;
    assign frame_det = dataOut & ~data_prev;
    assign cnt_inc   = bad_cnt + 4'd1;

    // ------------------------------------------------------------------
    // Next-state decision, evaluated only on a frame-detect cycle.
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path
    // leaves a value unassigned and no latch can be inferred.
    always_comb begin
        nxt_state = cur_state;
        nxt_cnt   = bad_cnt;
        nxt_code  = faultCode;

        if (frame_det) begin
            unique case (cur_state)
                ST_FAULT: begin
                    nxt_code = faultCode | bad_bits;
                    if (clearFault && !frame_bad) begin
                        nxt_state = ST_NORMAL;
                        nxt_cnt   = 4'd0;
                        nxt_code  = 4'd0;
                    end
                end

                ST_WARN: begin
                    nxt_code = bad_bits;
                    if (frame_bad) begin
                        nxt_cnt   = cnt_inc;
                        nxt_state = escalate(cnt_inc, DEB);
                    end else begin
                        nxt_cnt   = 4'd0;
                        nxt_state = ST_NORMAL;
                    end
                end

                default: begin
                    nxt_code = bad_bits;
                    if (frame_bad) begin
                        nxt_cnt   = 4'd1;
                        nxt_state = escalate(4'd1, DEB);
                    end else begin
                        nxt_cnt   = 4'd0;
                        nxt_state = ST_NORMAL;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State and registered outputs.
    // ------------------------------------------------------------------
    // NOTE: all state updates here use non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cur_state <= ST_IDLE;
            bad_cnt   <= 4'd0;
            faultCode <= 4'd0;
            faultFlag <= 1'b0;
            warnFlag  <= 1'b0;
            frameCnt  <= 16'd0;
            evalDone  <= 1'b0;
            // History of 1 keeps a level held high through reset from
            // looking like a fresh rising edge on release.
            data_prev <= 1'b1;
        end else begin
            data_prev <= dataOut;
            evalDone  <= frame_det;
            cur_state <= nxt_state;
            bad_cnt   <= nxt_cnt;
            faultCode <= nxt_code;
            faultFlag <= (nxt_state == ST_FAULT);
            warnFlag  <= (nxt_state == ST_WARN);
            if (frame_det) begin
                frameCnt <= frameCnt + 16'd1;
            end
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_amp_fault_monitor.sv
// Self-checking bench for amp_fault_monitor: a real-valued behavioural model
// checked every cycle, plus hand-computed expectations after each frame.
module tb_amp_fault_monitor;

    localparam logic [31:0] OVER  = 32'h42C80000;  // 100.0
    localparam logic [31:0] UNBAL = 32'h3DCCCCCD;  // 0.1
    localparam int          DEB   = 3;

    localparam logic [31:0] F_50    = 32'h42480000;
    localparam logic [31:0] F_150   = 32'h43160000;
    localparam logic [31:0] F_M150  = 32'hC3160000;
    localparam logic [31:0] F_0_02  = 32'h3CA3D70A;
    localparam logic [31:0] F_0_5   = 32'h3F000000;
    localparam logic [31:0] F_NAN   = 32'h7FC00000;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             dataOut = 1'b0;
    logic             clearFault = 1'b0;
    logic [2:0][31:0] amp;
    logic [31:0]      coff;
    logic [1:0]       state;
    logic             faultFlag;
    logic             warnFlag;
    logic [3:0]       faultCode;
    logic [15:0]      frameCnt;
    logic             evalDone;

    int total = 0;
    int bad   = 0;
    bit done  = 1'b0;

    // Model state (0 IDLE, 1 NORMAL, 2 WARN, 3 FAULT)
    int m_state  = 0;
    int m_cnt    = 0;
    int m_code   = 0;
    int m_frames = 0;
    bit m_eval   = 1'b0;
    bit m_prev   = 1'b1;

    always #5 clk = ~clk;

    amp_fault_monitor #(
        .OVER_TH    (OVER),
        .UNBAL_TH   (UNBAL),
        .DEBOUNCE_N (DEB)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .dataOut    (dataOut),
        .Amp        (amp),
        .Coff       (coff),
        .clearFault (clearFault),
        .state      (state),
        .faultFlag  (faultFlag),
        .warnFlag   (warnFlag),
        .faultCode  (faultCode),
        .frameCnt   (frameCnt),
        .evalDone   (evalDone)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Magnitude of a finite float32 as a real, decoded from its fields.
    function automatic real fmag(input logic [31:0] x);
        int  e = int'(x[30:23]);
        real m = real'(x[22:0]);
        if (e == 0) return m * (2.0 ** -149);
        return (m + 8388608.0) * (2.0 ** (e - 150));
    endfunction

    function automatic bit over(input logic [31:0] x, input logic [31:0] th);
        if (x[30:23] == 8'hFF) return 1'b1;
        return fmag(x) > fmag(th);
    endfunction

    function automatic int bad_bits_of(input logic [2:0][31:0] a, input logic [31:0] c);
        int b = 0;
        for (int i = 0; i < 3; i++) if (over(a[i], OVER)) b |= (1 << i);
        if (over(c, UNBAL)) b |= 8;
        return b;
    endfunction

    // Behavioural model, advanced on each rising edge from the rules.
    initial begin
        forever begin
            @(posedge clk);
            if (!rstn) begin
                m_state = 0; m_cnt = 0; m_code = 0; m_frames = 0;
                m_eval = 1'b0; m_prev = 1'b1;
            end else begin
                m_eval = 1'b0;
                if (dataOut && !m_prev) begin
                    int bits;
                    bits     = bad_bits_of(amp, coff);
                    m_eval   = 1'b1;
                    m_frames = (m_frames + 1) % 65536;
                    if (m_state == 3) begin
                        m_code |= bits;
                        if (clearFault && bits == 0) begin
                            m_state = 1; m_code = 0; m_cnt = 0;
                        end
                    end else begin
                        m_code = bits;
                        if (bits != 0) begin
                            m_cnt   = (m_state == 2) ? m_cnt + 1 : 1;
                            m_state = (m_cnt >= DEB) ? 3 : 2;
                        end else begin
                            m_cnt   = 0;
                            m_state = 1;
                        end
                    end
                end
                m_prev = dataOut;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (!done) begin
                check("state",     32'(state),     32'(m_state));
                check("faultFlag", 32'(faultFlag), 32'(m_state == 3));
                check("warnFlag",  32'(warnFlag),  32'(m_state == 2));
                check("faultCode", 32'(faultCode), 32'(m_code));
                check("frameCnt",  32'(frameCnt),  32'(m_frames));
                check("evalDone",  32'(evalDone),  32'(m_eval));
            end
        end
    end

    task automatic frame(input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] a2, input logic [31:0] c,
                         input logic clr);
        @(negedge clk);
        amp[0] = a0; amp[1] = a1; amp[2] = a2; coff = c;
        clearFault = clr;
        dataOut = 1'b1;
        @(negedge clk);
        dataOut = 1'b0;
        clearFault = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input logic [1:0] st,
                              input logic [3:0] code, input logic [15:0] cnt);
        check({tag, "_state"}, 32'(state),     32'(st));
        check({tag, "_code"},  32'(faultCode), 32'(code));
        check({tag, "_cnt"},   32'(frameCnt),  32'(cnt));
    endtask

    initial begin
        amp[0] = F_50; amp[1] = F_50; amp[2] = F_50; coff = F_0_02;
        repeat (3) @(negedge clk);
        expect_out("reset", 2'd0, 4'd0, 16'd0);
        check("reset_eval", 32'(evalDone), 32'd0);
        rstn = 1'b1;

        // Nominal frames
        frame(F_50, F_50, F_50, F_0_02, 1'b0);
        expect_out("good1", 2'd1, 4'd0, 16'd1);
        frame(F_50, F_50, F_50, F_0_02, 1'b0);
        frame(F_50, F_50, F_50, F_0_02, 1'b0);
        expect_out("good3", 2'd1, 4'd0, 16'd3);

        // Phase B over threshold, debounced to FAULT
        frame(F_50, F_150, F_50, F_0_02, 1'b0);
        expect_out("b1", 2'd2, 4'b0010, 16'd4);
        frame(F_50, F_150, F_50, F_0_02, 1'b0);
        expect_out("b2", 2'd2, 4'b0010, 16'd5);
        frame(F_50, F_150, F_50, F_0_02, 1'b0);
        expect_out("b3", 2'd3, 4'b0010, 16'd6);
        check("b3_fflag", 32'(faultFlag), 32'd1);

        // Clear refused on a bad frame, accepted on a good one
        frame(F_50, F_50, F_50, F_0_5, 1'b1);
        expect_out("clr_bad", 2'd3, 4'b1010, 16'd7);
        frame(F_50, F_50, F_50, F_0_02, 1'b1);
        expect_out("clr_good", 2'd1, 4'b0000, 16'd8);

        // Two bad, one good, then one bad restarts the count
        frame(F_50, F_150, F_50, F_0_02, 1'b0);
        frame(F_50, F_150, F_50, F_0_02, 1'b0);
        expect_out("w2", 2'd2, 4'b0010, 16'd10);
        frame(F_50, F_50, F_50, F_0_02, 1'b0);
        expect_out("recover", 2'd1, 4'd0, 16'd11);
        frame(F_50, F_150, F_50, F_0_02, 1'b0);
        expect_out("restart", 2'd2, 4'b0010, 16'd12);
        frame(F_50, F_50, F_50, F_0_02, 1'b0);

        // Values equal to thresholds are good; clearFault outside FAULT ignored
        frame(OVER, OVER, OVER, UNBAL, 1'b1);
        expect_out("equal", 2'd1, 4'd0, 16'd14);

        // NaN on A and negative over-threshold on C
        frame(F_NAN, F_50, F_M150, F_0_02, 1'b0);
        expect_out("nan1", 2'd2, 4'b0101, 16'd15);
        frame(F_NAN, F_50, F_M150, F_0_02, 1'b0);
        frame(F_NAN, F_50, F_M150, F_0_02, 1'b0);
        expect_out("nan3", 2'd3, 4'b0101, 16'd17);

        // clearFault with no frame keeps FAULT
        amp[0] = F_50; amp[2] = F_50;
        clearFault = 1'b1;
        repeat (4) @(negedge clk);
        clearFault = 1'b0;
        expect_out("clr_noframe", 2'd3, 4'b0101, 16'd17);

        // Held-high level yields one frame only
        dataOut = 1'b1;
        repeat (5) @(negedge clk);
        expect_out("held", 2'd3, 4'b0101, 16'd18);

        // Reset in FAULT with dataOut held high, then release while still high
        rstn = 1'b0;
        @(negedge clk);
        expect_out("rst_fault", 2'd0, 4'd0, 16'd0);
        check("rst_fflag", 32'(faultFlag), 32'd0);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        expect_out("rel_high", 2'd0, 4'd0, 16'd0);
        dataOut = 1'b0;
        @(negedge clk);
        frame(F_50, F_50, F_50, F_0_02, 1'b0);
        expect_out("after_rst", 2'd1, 4'd0, 16'd1);

        repeat (2) @(negedge clk);
        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
